uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/periplex_uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 15 +
 rtl/uart_rx_framer.sv | 109 ++++++++++
 3 files changed

// File: rtl/periplex_uart_pkg.sv
// periplex_uart_pkg: shared UART types and constants (UART_RX_PARITY_EN adds the parity state)
package periplex_uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;
`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with configurable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver with one-byte holding register (UART_RX_PARITY_EN adds even parity)
module uart_rx_framer
  import periplex_uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_ready,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = S_PARITY;
  logic par_bad;
`else
  localparam rx_state_t AFTER_DATA = S_STOP;
  localparam logic par_bad = 1'b0;
`endif
  rx_state_t state;
  logic [TW-1:0] timer;
  logic [$clog2(DATA_BITS)-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic rx_s, armed, tick;
  sync_2ff #(.RST_VAL(IDLE_LEVEL)) u_sync (
    .clk(clk1),
    .rst(rst),
    .d(i_rx_serial),
    .q(rx_s)
  );
  assign tick = timer == T_FULL;
  assign o_busy = state != S_IDLE;
  // frame FSM, bit timer, shifter and holding register; armed blocks a start until the line is seen idle after reset
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      idx         <= '0;
      shreg       <= '0;
      armed       <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_rx_byte   <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (i_rx_ready) o_rx_valid <= 1'b0;
      if (rx_s == IDLE_LEVEL) armed <= 1'b1;
      case (state)
        S_IDLE:
          if (armed && rx_s != IDLE_LEVEL) begin
            state <= S_START;
            timer <= '0;
          end
        S_START:
          if (timer == T_HALF) begin
            timer <= '0;
            state <= rx_s == IDLE_LEVEL ? S_IDLE : S_DATA;
          end else timer <= timer + 1'b1;
        S_DATA:
          if (tick) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (&idx) state <= AFTER_DATA;
          end else timer <= timer + 1'b1;
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (tick) begin
            timer       <= '0;
            par_bad     <= even_parity_err(shreg, rx_s);
            o_frame_err <= even_parity_err(shreg, rx_s);
            state       <= S_STOP;
          end else timer <= timer + 1'b1;
`endif
        S_STOP:
          if (tick) begin
            timer <= '0;
            if (rx_s == IDLE_LEVEL) begin
              state <= S_IDLE;
              if (!par_bad) begin
                if (!o_rx_valid || i_rx_ready) begin
                  o_rx_byte  <= shreg;
                  o_rx_valid <= 1'b1;
                end else o_overrun <= 1'b1;
              end
            end else begin
              state       <= S_WAIT_IDLE;
              o_frame_err <= !par_bad;
            end
          end else timer <= timer + 1'b1;
        S_WAIT_IDLE:
          if (rx_s == IDLE_LEVEL) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule
